// File: rtl/sram_bridge.sv
// rtl/sram_bridge.sv - byte-wide CPU port to 256Kx16 async SRAM bridge with one-word read buffer
// Optional feature macro: SRAM_BRIDGE_WORDBUF_EN (word buffer hit path and write-through).
module sram_bridge (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WSETUP,
    S_WPULSE,
    S_WDONE
  } state_t;

  state_t      state_q;
  logic [15:0] buf_data_q;
  logic [17:0] buf_tag_q;
  logic        buf_valid_q;
  logic [17:0] sram_addr_q;
  logic [15:0] dq_out_q;
  logic        dq_oe_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        ub_n_q;
  logic        lb_n_q;

  logic        mapped;
  logic        hit;

  assign mapped = ~cpu_address[19];

  // Without the word buffer, buf_valid only survives the single IDLE cycle after READ,
  // so this same compare acts as the "read just finished" indication.
  assign hit = buf_valid_q && (buf_tag_q == cpu_address[18:1]) && mapped;

  // Pins come straight from registers; the data bus is released unless a write is in flight.
  assign sram_addr = sram_addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_ub_n = ub_n_q;
  assign sram_lb_n = lb_n_q;
  assign sram_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;

  // Handshake to the core: IDLE completes hits and unmapped accesses, WDONE completes writes.
  always_comb begin
    cpu_ready = 1'b0;
    case (state_q)
      S_IDLE:  cpu_ready = mapped ? (hit && !cpu_we) : 1'b1;
      S_WDONE: cpu_ready = 1'b1;
      default: cpu_ready = 1'b0;
    endcase
  end

  // Read byte is steered out of the buffered word; unmapped space reads as all ones.
  always_comb begin
    cpu_rdata = 8'hFF;
    if (mapped) begin
      cpu_rdata = cpu_address[0] ? buf_data_q[15:8] : buf_data_q[7:0];
    end
  end

  // Bridge FSM: strobes are loaded on the edge entering each state so they are glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      buf_data_q  <= 16'h0000;
      buf_tag_q   <= 18'h0;
      buf_valid_q <= 1'b0;
      sram_addr_q <= 18'h0;
      dq_out_q    <= 16'h0000;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
`ifndef SRAM_BRIDGE_WORDBUF_EN
          buf_valid_q <= 1'b0;
`endif
          if (mapped && cpu_we) begin
            sram_addr_q <= cpu_address[18:1];
            dq_out_q    <= {cpu_wdata, cpu_wdata};
            dq_oe_q     <= 1'b1;
            ce_n_q      <= 1'b0;
            we_n_q      <= 1'b1;
            ub_n_q      <= ~cpu_address[0];
            lb_n_q      <= cpu_address[0];
            state_q     <= S_WSETUP;
          end else if (mapped && !hit) begin
            sram_addr_q <= cpu_address[18:1];
            ce_n_q      <= 1'b0;
            oe_n_q      <= 1'b0;
            ub_n_q      <= 1'b0;
            lb_n_q      <= 1'b0;
            state_q     <= S_READ;
          end
        end
        S_READ: begin
          buf_data_q  <= sram_dq;
          buf_tag_q   <= sram_addr_q;
          buf_valid_q <= 1'b1;
          ce_n_q      <= 1'b1;
          oe_n_q      <= 1'b1;
          ub_n_q      <= 1'b1;
          lb_n_q      <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_WSETUP: begin
          we_n_q  <= 1'b0;
          state_q <= S_WPULSE;
        end
        S_WPULSE: begin
          we_n_q  <= 1'b1;
          state_q <= S_WDONE;
`ifdef SRAM_BRIDGE_WORDBUF_EN
          // Keep the buffered word coherent with the byte just written to SRAM.
          if (buf_valid_q && (buf_tag_q == sram_addr_q)) begin
            if (!ub_n_q) buf_data_q[15:8] <= dq_out_q[15:8];
            if (!lb_n_q) buf_data_q[7:0]  <= dq_out_q[7:0];
          end
`endif
        end
        S_WDONE: begin
          dq_oe_q <= 1'b0;
          ce_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
